capture_seq: RTL and testbench
==============================

# capture_seq

Capture and read-out sequencer for the logic-analyzer sample RAM. It sequences circular writes of decimated samples, arms the trigger once enough pre-trigger history is stored, and counts `trig_pos` post-trigger samples. It then raises `set_capture_done` toward `cmd_cfg` and steps the RAM read address for the UART channel dump driven by `strt_rd`/`rd_done`. It sits between the trigger logic, the decimator strobe, the five channel RAMs and `cmd_cfg`.

## Interface
Parameters:
- `ENTRIES`, 384: sample RAM depth (need not be a power of two)
- `LOG2`, 9: address width, ≥ clog2(ENTRIES)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `run`  in  1  1-cycle pulse; starts or restarts a capture
- `smpl_en`  in  1  decimated sample strobe
- `triggered`  in  1  trigger-condition level from trigger logic
- `trig_pos`  in  LOG2  number of post-trigger samples
- `strt_rd`  in  1  1-cycle pulse from `cmd_cfg`; request the next dump byte
- `we`  out  1  RAM write enable (all channels)
- `waddr`  out  LOG2  RAM write address
- `raddr`  out  LOG2  RAM read address
- `armed`  out  1  pre-trigger history complete; trigger accepted
- `capture_busy`  out  1  high in PRETRIG/POSTTRIG
- `set_capture_done`  out  1  1-cycle pulse at end of capture
- `rd_done`  out  1  1-cycle pulse; dump finished or rejected

## Operation
- States: IDLE, PRETRIG, POSTTRIG, DONE. On `rst`, state is IDLE and all outputs and counters are 0.
- `tp_eff = min(trig_pos, ENTRIES-1)`. This value is sampled on `run` and held for the rest of the capture.
- `run` in any state:
  - clear `waddr`, `pre_cnt`, `post_cnt`, `rd_cnt` and `armed`
  - go to PRETRIG
  - `run` takes priority over a coincident `smpl_en`; that sample is not written.
- PRETRIG:
  - `we = smpl_en`. Each write increments `waddr` modulo ENTRIES (ENTRIES-1 → 0).
  - `pre_cnt` counts writes and saturates at ENTRIES.
  - `armed` is set when `pre_cnt ≥ ENTRIES - tp_eff`.
  - `triggered` is ignored while `armed` = 0; it is not latched.
  - When `triggered` and `armed` are both 1, go to POSTTRIG. A sample written in that same cycle counts as pre-trigger.
- POSTTRIG:
  - `we = smpl_en`; `post_cnt` increments on each write.
  - When `post_cnt` reaches `tp_eff`, pulse `set_capture_done` and go to DONE.
  - With `tp_eff` = 0, the transition happens in the cycle after the trigger, with no further writes.
- DONE:
  - `we` = 0.
  - On entry, `raddr` is loaded with `waddr`, the oldest sample.
  - Each `strt_rd` with `rd_cnt < ENTRIES`: `raddr` is valid in that cycle, and RAM data is valid the next cycle. Then `raddr` increments modulo ENTRIES and `rd_cnt` increments.
  - `strt_rd` with `rd_cnt == ENTRIES` produces a `rd_done` pulse in the next cycle.
- `strt_rd` in IDLE, PRETRIG or POSTTRIG produces a `rd_done` pulse in the next cycle, with no address change, so `cmd_cfg` never hangs.
- All counters are LOG2+1 bits wide so that the value ENTRIES is representable. There is no other arithmetic overflow.

## Timing
- `we` is combinational from `smpl_en` and state, valid in the `smpl_en` cycle; `waddr` updates on that edge.
- `armed` is registered: high the cycle after the qualifying write.
- `set_capture_done` is registered: it pulses in the cycle after the final post-trigger write.
- `rd_done` is registered, one cycle after `strt_rd`. This matches `cmd_cfg` REQDUMP, which samples `rd_done` the cycle after it issues `strt_rd`.
- `rst` mid-capture or mid-dump:
  - return to IDLE immediately
  - no `set_capture_done` or `rd_done` pulse is generated.

## Structure
- Shared package `la_pkg` holds the `ENTRIES`/`LOG2` defaults and the `capseq_state_t` enum. `cmd_cfg` and the RAM wrappers import the same constants.
- One sub-module, `wrap_cnt`: a modulo-ENTRIES address counter with `clr`, `load`, `inc`. It is instantiated twice, for `waddr` and `raddr`.

## Test plan
- **Reset:** assert `rst` 2 cycles → all outputs are 0 and state is IDLE. `smpl_en` pulses in IDLE → `we` stays 0.
- **Nominal capture:** `trig_pos`=1, `run`, hold `triggered`=1, 383 `smpl_en` → `armed` rises after write 383 and the sequencer enters POSTTRIG. One more `smpl_en` (write 384, `waddr` wraps 383→0) → `set_capture_done` pulse the next cycle; 384 writes in total.
- **Early trigger:** `trig_pos`=100; `triggered` pulses after 10 samples → ignored, still PRETRIG. `armed` rises after write 284; trigger then 100 samples → done, with `raddr` = `waddr`.
- **Dump:** after capture, 384 `strt_rd` pulses → `raddr` runs from the oldest address through the wrap, with no `rd_done`. 385th `strt_rd` → `rd_done` pulse the next cycle. `strt_rd` before any capture → immediate `rd_done`.
- **Restart:** `run` during POSTTRIG with a coincident `smpl_en` → no write, `waddr`=0, `armed`=0, PRETRIG. `rst` mid-dump → IDLE, no `rd_done`.
- **Bounds:** `trig_pos`=0 → `armed` after 384 writes, done the cycle after the trigger. `trig_pos`=500 → behaves as 383: `armed` after 1 write, done after 383 post-trigger writes.

Source files
------------

// File: rtl/la_pkg.sv
// Shared logic-analyzer constants and the capture sequencer state type.
// cmd_cfg and the RAM wrappers pull their sizing from here too.
package la_pkg;

    localparam int LA_ENTRIES = 384;
    localparam int LA_LOG2    = 9;

    typedef enum logic [1:0] {
        IDLE,
        PRETRIG,
        POSTTRIG,
        DONE
    } capseq_state_t;

endpackage

// File: rtl/wrap_cnt.sv
// Modulo-ENTRIES address counter; ENTRIES need not be a power of two.
// Priority is clr over load over inc.
module wrap_cnt
    import la_pkg::*;
#(
    parameter int ENTRIES = LA_ENTRIES,
    parameter int LOG2    = LA_LOG2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            load,
    input  logic [LOG2-1:0] load_val,
    input  logic            inc,
    output logic [LOG2-1:0] cnt
);

    localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc) begin
            cnt <= (cnt == LAST) ? '0 : cnt + LOG2'(1);
        end
    end

endmodule

// File: rtl/capture_seq.sv
// Capture and read-out sequencer for the logic-analyzer sample RAM:
// circular pre-trigger writes, post-trigger count, then paced dump addressing.
module capture_seq
    import la_pkg::*;
#(
    parameter int ENTRIES = LA_ENTRIES,
    parameter int LOG2    = LA_LOG2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            smpl_en,
    input  logic            triggered,
    input  logic [LOG2-1:0] trig_pos,
    input  logic            strt_rd,
    output logic            we,
    output logic [LOG2-1:0] waddr,
    output logic [LOG2-1:0] raddr,
    output logic            armed,
    output logic            capture_busy,
    output logic            set_capture_done,
    output logic            rd_done
);

    localparam logic [LOG2:0]   ENT  = (LOG2+1)'(ENTRIES);
    localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

    capseq_state_t   state;
    logic [LOG2-1:0] tp_eff;
    logic [LOG2:0]   tp_ext;
    logic [LOG2:0]   pre_cnt;
    logic [LOG2:0]   pre_nxt;
    logic [LOG2:0]   post_cnt;
    logic [LOG2:0]   rd_cnt;
    logic            we_int;
    logic            post_room;
    logic            post_last;
    logic            arm_hit;
    logic            rd_ok;
    logic            rd_step;
    logic [LOG2-1:0] waddr_inc;
    logic [LOG2-1:0] raddr_load;

    assign tp_ext       = {1'b0, tp_eff};
    assign post_room    = post_cnt < tp_ext;
    assign capture_busy = (state == PRETRIG) || (state == POSTTRIG);

    // run wins over a coincident sample, and a capture stops writing once tp_eff is reached
    assign we_int = smpl_en && !run && !rst &&
                    ((state == PRETRIG) || ((state == POSTTRIG) && post_room));
    assign we     = we_int;

    assign pre_nxt   = (we_int && (state == PRETRIG) && (pre_cnt < ENT)) ?
                       pre_cnt + (LOG2+1)'(1) : pre_cnt;
    assign arm_hit   = (state == PRETRIG) && (pre_nxt >= ENT - tp_ext);
    assign post_last = (state == POSTTRIG) && !run &&
                       (!post_room || (we_int && (post_cnt + (LOG2+1)'(1) == tp_ext)));

    assign rd_ok   = (state == DONE) && (rd_cnt < ENT);
    assign rd_step = strt_rd && rd_ok && !run;

    // The dump starts at the oldest sample, which is where the final write leaves waddr
    assign waddr_inc  = (waddr == LAST) ? '0 : waddr + LOG2'(1);
    assign raddr_load = we_int ? waddr_inc : waddr;

    wrap_cnt #(
        .ENTRIES (ENTRIES),
        .LOG2    (LOG2)
    ) u_wcnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (run),
        .load     (1'b0),
        .load_val ('0),
        .inc      (we_int),
        .cnt      (waddr)
    );

    wrap_cnt #(
        .ENTRIES (ENTRIES),
        .LOG2    (LOG2)
    ) u_rcnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (1'b0),
        .load     (post_last),
        .load_val (raddr_load),
        .inc      (rd_step),
        .cnt      (raddr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            tp_eff           <= '0;
            pre_cnt          <= '0;
            post_cnt         <= '0;
            rd_cnt           <= '0;
            armed            <= 1'b0;
            set_capture_done <= 1'b0;
            rd_done          <= 1'b0;
        end else begin
            set_capture_done <= 1'b0;
            // Any read request that will not step the address is answered so cmd_cfg never stalls
            rd_done          <= strt_rd && (run || !rd_ok);
            if (run) begin
                state    <= PRETRIG;
                tp_eff   <= (trig_pos > LAST) ? LAST : trig_pos;
                pre_cnt  <= '0;
                post_cnt <= '0;
                rd_cnt   <= '0;
                armed    <= 1'b0;
            end else begin
                case (state)
                    PRETRIG: begin
                        pre_cnt <= pre_nxt;
                        if (arm_hit) begin
                            armed <= 1'b1;
                        end
                        if (triggered && armed) begin
                            state <= POSTTRIG;
                        end
                    end
                    POSTTRIG: begin
                        if (we_int) begin
                            post_cnt <= post_cnt + (LOG2+1)'(1);
                        end
                        if (post_last) begin
                            state            <= DONE;
                            set_capture_done <= 1'b1;
                        end
                    end
                    DONE: begin
                        if (rd_step) begin
                            rd_cnt <= rd_cnt + (LOG2+1)'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_capture_seq.sv
// Self-checking bench for capture_seq: a vector table, directed capture/dump
// sequences, and randomized traffic against a counter-based reference model.
module tb_capture_seq;

    localparam int ENTRIES = 384;
    localparam int LOG2    = 9;
    localparam int P_IDLE  = 0;
    localparam int P_PRE   = 1;
    localparam int P_POST  = 2;
    localparam int P_DONE  = 3;
    localparam int NV      = 11;

    logic            clk = 1'b0;
    logic            rst;
    logic            run;
    logic            smpl_en;
    logic            triggered;
    logic [LOG2-1:0] trig_pos;
    logic            strt_rd;
    logic            we;
    logic [LOG2-1:0] waddr;
    logic [LOG2-1:0] raddr;
    logic            armed;
    logic            capture_busy;
    logic            set_capture_done;
    logic            rd_done;

    capture_seq #(
        .ENTRIES (ENTRIES),
        .LOG2    (LOG2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .run              (run),
        .smpl_en          (smpl_en),
        .triggered        (triggered),
        .trig_pos         (trig_pos),
        .strt_rd          (strt_rd),
        .we               (we),
        .waddr            (waddr),
        .raddr            (raddr),
        .armed            (armed),
        .capture_busy     (capture_busy),
        .set_capture_done (set_capture_done),
        .rd_done          (rd_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit r_rst, r_run, r_smpl, r_trig;
        int r_tp;
        bit r_srd;
        bit e_we;
        int e_waddr;
        bit e_armed, e_busy, e_done, e_rdd;
    } vec_t;

    vec_t vecs [NV];

    int checks = 0;
    int passed = 0;

    // Reference model: capture progress as plain write/read counts
    int m_phase, m_nwr, m_npre, m_npost, m_nrd, m_rcur, m_tpe;
    bit m_we, m_done, m_rdd;

    bit o_we, o_armed, o_busy, o_done, o_rdd;
    int o_waddr, o_raddr;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    function automatic int modelArmed();
        int hist;
        hist = (m_npre < ENTRIES) ? m_npre : ENTRIES;
        return (m_phase != P_IDLE && hist >= ENTRIES - m_tpe) ? 1 : 0;
    endfunction

    task automatic modelStep(input bit r_rst, r_run, r_smpl, r_trig, input int r_tp, input bit r_srd);
        int armed_before;
        if (r_rst) begin
            m_phase = P_IDLE; m_nwr = 0; m_npre = 0; m_npost = 0; m_nrd = 0;
            m_rcur = 0; m_tpe = 0; m_we = 0; m_done = 0; m_rdd = 0;
            return;
        end
        armed_before = modelArmed();
        m_we  = r_smpl && !r_run && (m_phase == P_PRE || (m_phase == P_POST && m_npost < m_tpe));
        m_rdd = r_srd && (r_run || !(m_phase == P_DONE && m_nrd < ENTRIES));
        m_done = 0;
        if (r_run) begin
            m_phase = P_PRE; m_nwr = 0; m_npre = 0; m_npost = 0; m_nrd = 0;
            m_tpe = (r_tp > ENTRIES - 1) ? ENTRIES - 1 : r_tp;
        end else begin
            case (m_phase)
                P_PRE: begin
                    if (m_we) begin m_nwr++; m_npre++; end
                    if (r_trig && armed_before == 1) m_phase = P_POST;
                end
                P_POST: begin
                    if (m_we) begin m_nwr++; m_npost++; end
                    if (m_npost == m_tpe) begin
                        m_phase = P_DONE; m_done = 1; m_rcur = m_nwr % ENTRIES;
                    end
                end
                P_DONE: begin
                    if (r_srd && m_nrd < ENTRIES) begin
                        m_nrd++; m_rcur = (m_rcur + 1) % ENTRIES;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic applyStimulus(input bit r_rst, r_run, r_smpl, r_trig, input int r_tp, input bit r_srd);
        rst = r_rst; run = r_run; smpl_en = r_smpl; triggered = r_trig;
        trig_pos = LOG2'(r_tp); strt_rd = r_srd;
        @(negedge clk);
        o_we = we;
        @(posedge clk);
        #1;
        o_waddr = int'(waddr); o_raddr = int'(raddr); o_armed = armed;
        o_busy = capture_busy; o_done = set_capture_done; o_rdd = rd_done;
    endtask

    task automatic cycle(input bit r_rst, r_run, r_smpl, r_trig, input int r_tp, input bit r_srd);
        modelStep(r_rst, r_run, r_smpl, r_trig, r_tp, r_srd);
        applyStimulus(r_rst, r_run, r_smpl, r_trig, r_tp, r_srd);
        checkOutput("we", o_we, m_we);
        checkOutput("waddr", o_waddr, m_nwr % ENTRIES);
        checkOutput("raddr", o_raddr, m_rcur);
        checkOutput("armed", o_armed, modelArmed());
        checkOutput("capture_busy", o_busy, (m_phase == P_PRE || m_phase == P_POST) ? 1 : 0);
        checkOutput("set_capture_done", o_done, m_done);
        checkOutput("rd_done", o_rdd, m_rdd);
    endtask

    initial begin
        int cur_tp;
        bit r_run;
        rst = 1; run = 0; smpl_en = 0; triggered = 0; strt_rd = 0; trig_pos = '0;
        vecs[0]  = '{1,0,0,0,  0,0, 0,0,0,0,0,0};
        vecs[1]  = '{0,0,1,0,  0,0, 0,0,0,0,0,0};
        vecs[2]  = '{0,0,0,0,  0,1, 0,0,0,0,0,1};
        vecs[3]  = '{0,0,0,0,  0,0, 0,0,0,0,0,0};
        vecs[4]  = '{0,1,1,0,500,0, 0,0,0,1,0,0};
        vecs[5]  = '{0,0,1,1,500,0, 1,1,1,1,0,0};
        vecs[6]  = '{0,0,0,1,  0,0, 0,1,1,1,0,0};
        vecs[7]  = '{0,0,1,0,  0,0, 1,2,1,1,0,0};
        vecs[8]  = '{0,1,1,0,500,0, 0,0,0,1,0,0};
        vecs[9]  = '{0,0,0,0,  0,1, 0,0,0,1,0,1};
        vecs[10] = '{0,0,1,0,  0,0, 1,1,1,1,0,0};
        @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            cycle(vecs[i].r_rst, vecs[i].r_run, vecs[i].r_smpl, vecs[i].r_trig, vecs[i].r_tp, vecs[i].r_srd);
            checkOutput($sformatf("vec%0d_we", i), o_we, vecs[i].e_we);
            checkOutput($sformatf("vec%0d_waddr", i), o_waddr, vecs[i].e_waddr);
            checkOutput($sformatf("vec%0d_armed", i), o_armed, vecs[i].e_armed);
            checkOutput($sformatf("vec%0d_busy", i), o_busy, vecs[i].e_busy);
            checkOutput($sformatf("vec%0d_done", i), o_done, vecs[i].e_done);
            checkOutput($sformatf("vec%0d_rd_done", i), o_rdd, vecs[i].e_rdd);
        end

        // Reset, then samples in IDLE must not write
        repeat (2) cycle(1, 0, 0, 0, 0, 0);
        repeat (3) cycle(0, 0, 1, 0, 0, 0);

        // Nominal capture with trig_pos = 1
        cycle(0, 1, 0, 0, 1, 0);
        repeat (383) cycle(0, 0, 1, 1, 1, 0);
        checkOutput("nom_armed", o_armed, 1);
        cycle(0, 0, 0, 1, 1, 0);
        cycle(0, 0, 1, 1, 1, 0);
        checkOutput("nom_done", o_done, 1);
        checkOutput("nom_waddr_wrap", o_waddr, 0);
        checkOutput("nom_raddr", o_raddr, 0);
        cycle(0, 0, 0, 0, 1, 0);

        // Full dump then one extra request
        for (int i = 0; i < ENTRIES; i++) begin
            cycle(0, 0, 0, 0, 0, 1);
            checkOutput("dump_raddr", o_raddr, (i + 1) % ENTRIES);
            checkOutput("dump_no_rd_done", o_rdd, 0);
        end
        cycle(0, 0, 0, 0, 0, 1);
        checkOutput("dump_rd_done", o_rdd, 1);
        cycle(0, 0, 0, 0, 0, 0);

        // Early trigger with trig_pos = 100
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 0, 0, 100, 0);
        repeat (10) cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        checkOutput("early_ignored_busy", o_busy, 1);
        checkOutput("early_ignored_armed", o_armed, 0);
        repeat (273) cycle(0, 0, 1, 0, 0, 0);
        checkOutput("early_not_armed", o_armed, 0);
        cycle(0, 0, 1, 0, 0, 0);
        checkOutput("early_armed", o_armed, 1);
        cycle(0, 0, 0, 1, 0, 0);
        repeat (99) cycle(0, 0, 1, 0, 0, 0);
        checkOutput("early_not_done", o_done, 0);
        cycle(0, 0, 1, 0, 0, 0);
        checkOutput("early_done", o_done, 1);
        checkOutput("early_raddr", o_raddr, 0);

        // Restart during POSTTRIG with a coincident sample
        cycle(0, 1, 0, 0, 50, 0);
        repeat (334) cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        repeat (5) cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 1, 1, 0, 50, 0);
        checkOutput("restart_we", o_we, 0);
        checkOutput("restart_waddr", o_waddr, 0);
        checkOutput("restart_armed", o_armed, 0);
        checkOutput("restart_busy", o_busy, 1);

        // Finish that capture, start dumping, reset mid-dump
        repeat (334) cycle(0, 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        repeat (50) cycle(0, 0, 1, 0, 0, 0);
        repeat (5) cycle(0, 0, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 0, 1);
        checkOutput("rstdump_rd_done", o_rdd, 0);
        cycle(0, 0, 0, 0, 0, 0);
        checkOutput("rstdump_after", o_rdd, 0);

        // trig_pos = 0
        cycle(0, 1, 0, 0, 0, 0);
        repeat (383) cycle(0, 0, 1, 1, 0, 0);
        checkOutput("tp0_not_armed", o_armed, 0);
        cycle(0, 0, 1, 1, 0, 0);
        checkOutput("tp0_armed", o_armed, 1);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 1, 0, 0, 0);
        checkOutput("tp0_no_write", o_we, 0);
        checkOutput("tp0_done", o_done, 1);

        // trig_pos = 500 behaves as 383
        cycle(0, 1, 0, 0, 500, 0);
        cycle(0, 0, 1, 0, 0, 0);
        checkOutput("tp500_armed", o_armed, 1);
        cycle(0, 0, 0, 1, 0, 0);
        repeat (382) cycle(0, 0, 1, 0, 0, 0);
        checkOutput("tp500_not_done", o_done, 0);
        cycle(0, 0, 1, 0, 0, 0);
        checkOutput("tp500_done", o_done, 1);

        // Randomized traffic
        cur_tp = 0;
        for (int i = 0; i < 6000; i++) begin
            r_run = ($urandom % 700) == 0;
            if (r_run) begin
                case ($urandom % 4)
                    0: cur_tp = 0;
                    1: cur_tp = 1;
                    2: cur_tp = 500;
                    default: cur_tp = $urandom_range(0, 511);
                endcase
            end
            cycle(($urandom % 2500) == 0, r_run, ($urandom % 4) != 0, ($urandom % 8) == 0,
                  r_run ? cur_tp : $urandom_range(0, 511), ($urandom % 3) == 0);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
